// File: rtl/axil_regfile.sv
// ---------------------------------------------------------------------------
// axil_regfile -- parametrised AXI4-Lite slave register file
//
// Provides NUM_REGS read/write registers of DATA_WIDTH bits behind an
// AXI4-Lite slave port. Writes honour byte strobes. The AW and W channels may
// be accepted in either order or on the same edge. R and B channels support
// full backpressure. Out-of-range accesses complete with SLVERR and have no
// side effects.
//
// Optional build macro:
//   AXIL_REGFILE_PROT_EN - when defined, an access to register n with
//                          PRIV_MASK[n]=1 and AxPROT[0]=0 completes with SLVERR
//                          (write discarded, read data 0). When undefined,
//                          ARPROT/AWPROT and PRIV_MASK are ignored.
//
// Ports:
//   ACLK, ARESETN                 clock (rising edge), async active-low reset
//   ARADDR/ARPROT/ARVALID/ARREADY read address channel
//   RDATA/RRESP/RVALID/RREADY     read data channel
//   AWADDR/AWPROT/AWVALID/AWREADY write address channel
//   WDATA/WSTRB/WVALID/WREADY     write data channel
//   BRESP/BVALID/BREADY           write response channel
//
// Every output is driven directly from a flop.
// ---------------------------------------------------------------------------
module axil_regfile #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 8,
    parameter logic [31:0]         RESET_BASE = 32'h1FEB0000,
    parameter logic [NUM_REGS-1:0] PRIV_MASK  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    // read address
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    // read data
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    // write address
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    // write data
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    // write response
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] W_IDLE = 2'b00;
    localparam logic [1:0] W_ADDR = 2'b01;
    localparam logic [1:0] W_DATA = 2'b10;
    localparam logic [1:0] W_RESP = 2'b11;

    // -----------------------------------------------------------------------
    // Register storage (flattened view for the read mux)
    // -----------------------------------------------------------------------
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_vals;

    // -----------------------------------------------------------------------
    // Read channel state
    // -----------------------------------------------------------------------
    logic [0:0]            r_state_reg;
    logic                  arready_reg;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    logic [31:0]           rd_idx;
    logic [NUM_REGS-1:0]   rd_hit;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_err;
    logic                  ar_hs;

    // -----------------------------------------------------------------------
    // Write channel state
    // -----------------------------------------------------------------------
    logic [1:0]            w_state_reg;
    logic                  awready_reg;
    logic                  wready_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]     wstrb_reg;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [31:0]           wr_idx;
    logic [NUM_REGS-1:0]   wr_hit;
    logic                  wr_err;

    assign ar_hs = ARVALID & arready_reg;
    assign aw_hs = AWVALID & awready_reg;
    assign w_hs  = WVALID  & wready_reg;

    // Byte-offset bits are dropped; an index outside the register range
    // simply produces no hit, which is what flags the access as out of range.
    assign rd_idx = 32'(ARADDR >> OFFS);
    assign wr_idx = 32'(wr_addr >> OFFS);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign rd_hit[gi] = (rd_idx == 32'(gi));
            assign wr_hit[gi] = (wr_idx == 32'(gi));
        end
    endgenerate

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_hit[i]) begin
                rd_val = reg_vals[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Commit source selection: whichever half of the write arrived earlier
    // comes from the holding registers, the other half from the live bus.
    // -----------------------------------------------------------------------
`ifdef AXIL_REGFILE_PROT_EN
    logic awprot0_reg;
    logic wr_prot0;
`endif

    always_comb begin
        commit_en = 1'b0;
        wr_addr   = AWADDR;
        wr_data   = WDATA;
        wr_strb   = WSTRB;
`ifdef AXIL_REGFILE_PROT_EN
        wr_prot0  = AWPROT[0];
`endif
        case (w_state_reg)
            W_IDLE: begin
                commit_en = aw_hs & w_hs;
            end
            W_ADDR: begin
                commit_en = w_hs;
                wr_addr   = waddr_reg;
`ifdef AXIL_REGFILE_PROT_EN
                wr_prot0  = awprot0_reg;
`endif
            end
            W_DATA: begin
                commit_en = aw_hs;
                wr_data   = wdata_reg;
                wr_strb   = wstrb_reg;
            end
            default: begin
                commit_en = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Error decode
    // -----------------------------------------------------------------------
`ifdef AXIL_REGFILE_PROT_EN
    // Privileged registers reject unprivileged (AxPROT[0]=0) accesses.
    assign rd_err = ~(|rd_hit) | ((|(rd_hit & PRIV_MASK)) & ~ARPROT[0]);
    assign wr_err = ~(|wr_hit) | ((|(wr_hit & PRIV_MASK)) & ~wr_prot0);

    logic unused_prot;
    assign unused_prot = ^{ARPROT[2:1], AWPROT[2:1]};
`else
    assign rd_err = ~(|rd_hit);
    assign wr_err = ~(|wr_hit);

    logic unused_prot;
    assign unused_prot = ^{ARPROT, AWPROT};
`endif

    // -----------------------------------------------------------------------
    // Registers: one flop bank per register with byte-granular enables
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [DATA_WIDTH-1:0] RST_VAL =
                DATA_WIDTH'(RESET_BASE + 32'(gi));

            logic [DATA_WIDTH-1:0] value_reg;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    value_reg <= RST_VAL;
                end else if (commit_en && wr_hit[gi] && !wr_err) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            value_reg[8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end

            assign reg_vals[gi] = value_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read FSM. ARREADY comes up on the first edge after reset release; the
    // register value is sampled on the AR handshake edge, so a write landing
    // on that same edge is not yet visible.
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_reg <= R_DATA;
                        arready_reg <= 1'b0;
                        rvalid_reg  <= 1'b1;
                        rdata_reg   <= rd_err ? '0 : rd_val;
                        rresp_reg   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                default: begin
                    if (RREADY) begin
                        r_state_reg <= R_IDLE;
                        arready_reg <= 1'b1;
                        rvalid_reg  <= 1'b0;
                        rdata_reg   <= '0;
                        rresp_reg   <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Write FSM. Each half of the write is held until its partner arrives;
    // the commit and the B response both happen on the edge entering W_RESP.
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
`ifdef AXIL_REGFILE_PROT_EN
            awprot0_reg <= 1'b0;
`endif
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        w_state_reg <= W_RESP;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b0;
                        bvalid_reg  <= 1'b1;
                        bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    end else if (aw_hs) begin
                        w_state_reg <= W_ADDR;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b1;
                        waddr_reg   <= AWADDR;
`ifdef AXIL_REGFILE_PROT_EN
                        awprot0_reg <= AWPROT[0];
`endif
                    end else if (w_hs) begin
                        w_state_reg <= W_DATA;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b0;
                        wdata_reg   <= WDATA;
                        wstrb_reg   <= WSTRB;
                    end else begin
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                    end
                end
                W_ADDR: begin
                    if (w_hs) begin
                        w_state_reg <= W_RESP;
                        wready_reg  <= 1'b0;
                        bvalid_reg  <= 1'b1;
                        bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                W_DATA: begin
                    if (aw_hs) begin
                        w_state_reg <= W_RESP;
                        awready_reg <= 1'b0;
                        bvalid_reg  <= 1'b1;
                        bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                default: begin
                    if (BREADY) begin
                        w_state_reg <= W_IDLE;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                        bvalid_reg  <= 1'b0;
                        bresp_reg   <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ARREADY = arready_reg;
    assign RVALID  = rvalid_reg;
    assign RDATA   = rdata_reg;
    assign RRESP   = rresp_reg;
    assign AWREADY = awready_reg;
    assign WREADY  = wready_reg;
    assign BVALID  = bvalid_reg;
    assign BRESP   = bresp_reg;

endmodule

// File: tb/tb_axil_regfile.sv
// ---------------------------------------------------------------------------
// tb_axil_regfile -- directed scoreboard bench for axil_regfile (default
// parameters: 8 x 32-bit registers, 8-bit address).
// Stimulus tasks push expected R/B responses into queues; a monitor pops and
// compares whenever a response handshake is presented.
// ---------------------------------------------------------------------------
module tb_axil_regfile;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [7:0]  ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [7:0]  AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;

    axil_regfile dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [33:0] rd_q[$];   // {RRESP, RDATA}
    logic [1:0]  wr_q[$];   // BRESP

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Wait (bounded) for a handshake on channel ch: 0=AW, 1=W, 2=AR.
    task automatic wait_hs(input int ch, input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge ACLK);
            ok = (ch == 0) ? AWREADY : (ch == 1) ? WREADY : ARREADY;
            tick();
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        rd_q.push_back({exp_resp, exp_data});
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = 1'b1;
        wait_hs(2, "ar_hs");
        ARVALID = 1'b0;
        check("rvalid_lat", 64'(RVALID), 64'd1);
        tick();
        RREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input logic [1:0] exp_resp);
        wr_q.push_back(exp_resp);
        fork
            begin
                repeat (aw_dly) tick();
                AWADDR  = addr;
                AWVALID = 1'b1;
                wait_hs(0, "aw_hs");
                AWVALID = 1'b0;
            end
            begin
                repeat (w_dly) tick();
                WDATA  = data;
                WSTRB  = strb;
                WVALID = 1'b1;
                wait_hs(1, "w_hs");
                WVALID = 1'b0;
            end
        join
        check("bvalid_lat", 64'(BVALID), 64'd1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_clr", 64'(BVALID), 64'd0);
    endtask

    // Scoreboard monitor: a response is consumed on the edge following a
    // negedge at which VALID and READY are both high.
    always @(negedge ACLK) begin
        logic [33:0] e;
        if (ARESETN && RVALID && RREADY) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h with no expected entry", RDATA);
            end else begin
                e = rd_q.pop_front();
                check("rdata", 64'(RDATA), 64'(e[31:0]));
                check("rresp", 64'(RRESP), 64'(e[33:32]));
            end
        end
        if (ARESETN && BVALID && BREADY) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_unexpected: got bresp %0h with no expected entry", BRESP);
            end else begin
                check("bresp", 64'(BRESP), 64'(wr_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_awready", 64'(AWREADY), 64'd0);
        check("rst_wready",  64'(WREADY),  64'd0);
        check("rst_rvalid",  64'(RVALID),  64'd0);
        check("rst_bvalid",  64'(BVALID),  64'd0);
        check("rst_rdata",   64'(RDATA),   64'd0);
        #2 ARESETN = 1'b1;
        tick();
        check("rel_arready", 64'(ARREADY), 64'd1);
        check("rel_awready", 64'(AWREADY), 64'd1);
        check("rel_wready",  64'(WREADY),  64'd1);

        // ---------------- default values ----------------
        axi_read(8'h00, 32'h1FEB0000, 2'b00);
        axi_read(8'h04, 32'h1FEB0001, 2'b00);
        axi_read(8'h08, 32'h1FEB0002, 2'b00);
        axi_read(8'h0C, 32'h1FEB0003, 2'b00);
        axi_read(8'h10, 32'h1FEB0004, 2'b00);
        axi_read(8'h14, 32'h1FEB0005, 2'b00);
        axi_read(8'h18, 32'h1FEB0006, 2'b00);
        axi_read(8'h1F, 32'h1FEB0007, 2'b00);   // low offset bits ignored

        // ---------------- AW+W same cycle ----------------
        axi_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
        axi_read(8'h08, 32'hDEADBEEF, 2'b00);

        // ---------------- W before AW, AW before W ----------------
        axi_write(8'h0C, 32'h000000AA, 4'h1, 3, 0, 2'b00);
        axi_write(8'h10, 32'h12345678, 4'hF, 0, 2, 2'b00);
        axi_read(8'h0C, 32'h1FEB00AA, 2'b00);
        axi_read(8'h10, 32'h12345678, 2'b00);

        // ---------------- WSTRB=0 ----------------
        axi_write(8'h1C, 32'hFFFFFFFF, 4'h0, 0, 0, 2'b00);
        axi_read(8'h1C, 32'h1FEB0007, 2'b00);

        // ---------------- out of range ----------------
        axi_write(8'h40, 32'h55555555, 4'hF, 0, 0, 2'b10);
        axi_read(8'h7C, 32'h00000000, 2'b10);
        axi_read(8'h00, 32'h1FEB0000, 2'b00);
        axi_read(8'h08, 32'hDEADBEEF, 2'b00);

        // ---------------- same-edge read and write ----------------
        fork
            axi_read(8'h04, 32'h1FEB0001, 2'b00);
            axi_write(8'h04, 32'h11111111, 4'hF, 0, 0, 2'b00);
        join
        axi_read(8'h04, 32'h11111111, 2'b00);

        // ---------------- backpressure ----------------
        rd_q.push_back({2'b00, 32'h1FEB0005});
        wr_q.push_back(2'b00);
        ARADDR = 8'h14; ARVALID = 1'b1; RREADY = 1'b0;
        AWADDR = 8'h18; AWVALID = 1'b1;
        WDATA = 32'hCAFEF00D; WSTRB = 4'b0101; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge ACLK);
        check("bp_ready_pre", 64'({ARREADY, AWREADY, WREADY}), 64'h7);
        tick();
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check("bp_rvalid",  64'(RVALID),  64'd1);
            check("bp_rdata",   64'(RDATA),   64'h1FEB0005);
            check("bp_rresp",   64'(RRESP),   64'd0);
            check("bp_bvalid",  64'(BVALID),  64'd1);
            check("bp_bresp",   64'(BRESP),   64'd0);
            check("bp_readies", 64'({ARREADY, AWREADY, WREADY}), 64'd0);
        end
        tick();
        RREADY = 1'b1; BREADY = 1'b1;
        tick();
        RREADY = 1'b0; BREADY = 1'b0;
        check("bp_released", 64'({RVALID, BVALID}), 64'd0);
        axi_read(8'h18, 32'h1FFE000D, 2'b00);

        // ---------------- reset during W_ADDR ----------------
        AWADDR = 8'h00; AWVALID = 1'b1;
        wait_hs(0, "rst_aw_hs");
        AWVALID = 1'b0;
        check("waddr_state", 64'({AWREADY, WREADY}), 64'h1);
        #2 ARESETN = 1'b0;
        #1;
        check("async_rst_ready", 64'({ARREADY, AWREADY, WREADY}), 64'd0);
        check("async_rst_valid", 64'({RVALID, BVALID}), 64'd0);
        WDATA = 32'h87654321; WSTRB = 4'hF; WVALID = 1'b1;
        repeat (2) tick();
        WVALID = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick();
        check("post_rst_ready", 64'({ARREADY, AWREADY, WREADY}), 64'h7);
        repeat (2) tick();
        check("post_rst_bvalid", 64'(BVALID), 64'd0);
        axi_read(8'h00, 32'h1FEB0000, 2'b00);
        axi_read(8'h18, 32'h1FEB0006, 2'b00);
        axi_read(8'h08, 32'h1FEB0002, 2'b00);

        // ---------------- drain ----------------
        repeat (2) tick();
        check("rd_q_empty", 64'(rd_q.size()), 64'd0);
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
Parametrised AXI4-Lite slave register file, successor to the team's fixed 8x32 AXI slave. Provides NUM_REGS read/write registers with byte-strobe writes, independent AW/W acceptance in any order, full R/B backpressure and SLVERR on out-of-range access. Sits behind the PS/interconnect AXI4-Lite master as the generic control/status register block.

Parameters:
DATA_WIDTH, 32, bus/register width; 32 or 64 only.
ADDR_WIDTH, 8, AxADDR width; 2^ADDR_WIDTH >= NUM_REGS*(DATA_WIDTH/8).
NUM_REGS, 8, number of registers, 1..64.
RESET_BASE, 32'h1FEB0000, register n resets to RESET_BASE + n, zero-extended to DATA_WIDTH.
PRIV_MASK, 0, NUM_REGS-bit mask; bit n set = register n privileged (used only with AXIL_REGFILE_PROT_EN).

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  reset, asynchronous assert, active-low
ARADDR  in  ADDR_WIDTH  read address
ARPROT  in  3  read protection
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
AWADDR  in  ADDR_WIDTH  write address
AWPROT  in  3  write protection
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready

Behaviour:
- Reset (ARESETN=0, async): registers = reset values; ARREADY/AWREADY/WREADY=0, RVALID=0, BVALID=0, RDATA=0, RRESP=00, BRESP=00; pending transactions dropped. First rising edge after release: ARREADY=AWREADY=WREADY=1.
- Decode: index = addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored. index >= NUM_REGS -> SLVERR (2'b10); else OKAY (2'b00).
- All outputs registered; no combinational input-to-output path.
- Read FSM R_IDLE (ARREADY=1) / R_DATA (RVALID=1, ARREADY=0).
  R_IDLE->R_DATA on ARVALID&ARREADY: RDATA = reg[index] sampled at that edge (0 if SLVERR), RRESP set. RVALID visible 1 cycle after AR handshake.
  R_DATA holds RDATA/RRESP stable until RVALID&RREADY; then ->R_IDLE, RVALID=0, RDATA=0, RRESP=00. Max one read per 2 cycles.
- Write FSM W_IDLE, W_ADDR (addr held, AWREADY=0, WREADY=1), W_DATA (data+strb held, WREADY=0, AWREADY=1), W_RESP (BVALID=1, AWREADY=WREADY=0).
  W_IDLE: AW only ->W_ADDR; W only ->W_DATA; both same cycle ->W_RESP. W_ADDR on W, W_DATA on AW ->W_RESP.
  Commit on edge entering W_RESP: byte i of reg[index] updated iff WSTRB[i]=1; SLVERR -> no update. BVALID/BRESP set same edge.
  W_RESP holds until BVALID&BREADY, then ->W_IDLE with AWREADY=WREADY=1 next cycle.
- WSTRB=0 with valid index: OKAY, no change.
- Read and write commit to same register on same edge: read returns pre-write value. Read accepted after BVALID seen returns new value.
- Read and write channels fully independent; neither stalls the other.
- AxPROT ignored unless AXIL_REGFILE_PROT_EN.

Optional Feature:
AXIL_REGFILE_PROT_EN: defined -> access to register n with PRIV_MASK[n]=1 and AxPROT[0]=0 returns SLVERR; write discarded, RDATA=0. Not defined -> ARPROT/AWPROT unused, PRIV_MASK ignored, only out-of-range gives SLVERR.

Test Plan:
Reset then read all 8 regs (defaults) -> RDATA=32'h1FEB0000..32'h1FEB0007, RRESP=00, RVALID one cycle after each AR handshake.
AW 0x08 and W 32'hDEADBEEF same cycle, WSTRB=4'hF -> BVALID next cycle, BRESP=00; read 0x08 -> 32'hDEADBEEF.
W (32'h000000AA, WSTRB=4'h1) 3 cycles before AW 0x0C; then AW 0x10 2 cycles before W 32'h12345678 -> reg3=32'h1FEB00AA, reg4=32'h12345678, one BVALID each.
Write 0x40 (index 16, NUM_REGS=8) and read 0x7C -> BRESP=10 / RRESP=10, RDATA=0, no register changed.
Hold RREADY=0 and BREADY=0 for 5 cycles -> RVALID/BVALID, RDATA, responses stable; ARREADY/AWREADY/WREADY stay 0 until handshake.
Assert ARESETN=0 mid-write in W_ADDR -> all valids/readies 0 immediately, regs back to defaults, no commit after release.
